seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the clock divider output. Takes the divider's slow square wave as a scan-rate strobe and time-multiplexes a hex value onto an N-digit common-anode seven-segment display.
- Runs entirely in the fast system clock domain. The divider output is treated as data: it is edge-detected and never used as a clock.
- Output pins go directly to the board's anode, segment and decimal-point pins.

Parameters:
- N_DIGITS, 8, number of display digits (2..8).
- IDX_W, $clog2(N_DIGITS), digit index width (localparam, derived).

Ports:
- clk_in  input  1  system clock.
- resetf  input  1  asynchronous reset, active-low.
- scan_tick  input  1  divided clock from the upstream divider, synchronous to clk_in.
- value  input  4*N_DIGITS  hex nibbles; nibble k shown on digit k, digit 0 rightmost.
- dp_mask  input  N_DIGITS  1 = decimal point lit on digit k.
- digit_en  input  N_DIGITS  1 = digit k enabled; 0 = digit k dark.
- anodes  output  N_DIGITS  active-low digit selects.
- segments  output  7  active-low; bit0 = CA … bit6 = CG.
- dp  output  1  active-low decimal point.

Behaviour:
- Reset (resetf = 0, asynchronous):
  - idx = 0, tick_q = 0, frame buffers = 0, phase = BLANK.
  - anodes all 1, segments = 7'h7F, dp = 1.
- Edge detect: tick_q <= scan_tick every cycle. edge = scan_tick & ~tick_q. Exactly one edge per divider period.
- Two-phase FSM:
  - BLANK: anodes all 1.
  - DRIVE: one digit selected.
  - On edge, from either phase:
    - idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
    - phase <= BLANK; anodes <= all 1.
    - If the new idx is 0, latch value, dp_mask and digit_en into the frame buffers. This is frame-atomic and prevents tearing.
  - In BLANK with no edge: phase <= DRIVE on the next cycle.
    - anodes <= ~(1 << idx), forced all 1 if buf_en[idx] = 0.
    - segments <= decode(buf_val[idx]).
    - dp <= ~buf_dp[idx].
  - In DRIVE with no edge: hold all outputs.
- Latency: edge cycle → anodes blank for exactly 1 cycle (anti-ghosting) → new digit driven on the following cycle.
- The first frame after reset latches the inputs on the first edge that wraps idx to 0.
  - Before that, digits 1..N-1 are scanned with buffers = 0.
  - With buf_en = 0 after reset, the display is dark.
- Edge arriving during BLANK: advances idx again and BLANK restarts. No digit is skipped in the output ordering beyond that index.
- scan_tick stuck high or low: no edges, so the current digit is held indefinitely.
- Reset mid-frame: immediate dark outputs; scan restarts from idx 0.
- Decode, all outputs registered. 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex, active-low).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - At frame latch, compute a blank mask covering the contiguous most-significant zero nibbles.
  - Digit 0 is never blanked.
  - Blanked digits behave as buf_en = 0.
  - A lit dp on a blanked digit still blanks the digit.
- Undefined: every enabled digit shows its nibble, including zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF = 7'h7F.
  - 16-entry active-low SEG_LUT constant.
  - typedef enum logic {BLANK, DRIVE} scan_phase_t.
- Sub-module hex_to_7seg: combinational nibble → segments via SEG_LUT, instantiated once on buf_val[idx].

Test Plan:
- Reset: hold resetf = 0 while toggling scan_tick → anodes = FF, segments = 7F, dp = 1. Release → still dark until the first frame latch.
- Basic scan: value = 32'h76543210, digit_en = FF, dp_mask = 00, then 16 edges.
  - After the wrap, each edge gives 1 cycle of anodes = FF.
  - Then anodes = FE with seg 40, FD with 79, FB with 24 … 7F with 78.
  - Wrap back to FE after digit 7.
- Frame atomicity: change value to 32'hFFFFFFFF while idx = 3 → digits 4..7 still show 4..7. After the wrap, all digits show 0E.
- Enable and dp: digit_en = 0F, dp_mask = 01 → digit 0 dp = 0; digits 4..7 give anodes = FF in their slots.
- Held scan_tick: hold scan_tick = 1 for 1000 cycles → outputs constant, idx unchanged. Assert resetf low mid-DRIVE → outputs go dark with no clock edge needed.
- With SEG7_LEADING_ZERO_BLANK_EN: value = 32'h00000420 → digits 3..7 dark, digits 2..0 show 4, 2, 0.
  - value = 0 → only digit 0 lit, showing 40.
  - Without the macro, the same stimulus lights all 8 digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns, bit0 = CA ... bit6 = CG; index 15 first
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {BLANK, DRIVE} scan_phase_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: scan strobe and frame inputs in, anode/segment pins out.
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                    scan_tick;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_mask;
  logic [N_DIGITS-1:0]     digit_en;
  logic [N_DIGITS-1:0]     anodes;
  logic [6:0]              segments;
  logic                    dp;

  modport master (output scan_tick, value, dp_mask, digit_en,
                  input  anodes, segments, dp);
  modport slave  (input  scan_tick, value, dp_mask, digit_en,
                  output anodes, segments, dp);
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);
  assign seg_c = SEG_LUT[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a hex frame onto an N-digit common-anode display.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8
)(
  input  logic                 clk_in,
  input  logic                 resetf,
  seg7_scan_driver_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_nxt_c;
  logic                      tick_q;
  logic                      edge_c;
  logic [N_DIGITS-1:0][3:0]  buf_val_q;
  logic [N_DIGITS-1:0]       buf_dp_q;
  logic [N_DIGITS-1:0]       buf_en_q;
  logic [N_DIGITS-1:0]       lz_mask_c;
  scan_phase_t               phase_q;
  logic [N_DIGITS-1:0]       anodes_q;
  logic [6:0]                segments_q;
  logic [6:0]                seg_c;
  logic                      dp_q;

  // The divider output is data: rising-edge detect only
  assign edge_c    = bus.scan_tick & ~tick_q;
  assign idx_nxt_c = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Contiguous run of zero nibbles from the MSB down; digit 0 always shown
  always_comb begin : lz_scan
    logic run;
    run       = 1'b1;
    lz_mask_c = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      run          = run & (bus.value[4*k +: 4] == 4'h0);
      lz_mask_c[k] = run;
    end
  end
`else
  assign lz_mask_c = '0;
`endif

  hex_to_7seg u_dec (
    .nibble (buf_val_q[idx_q]),
    .seg_c  (seg_c)
  );

  // Scan FSM: an edge always blanks for one cycle before the next digit drives
  always_ff @(posedge clk_in or negedge resetf) begin
    if (!resetf) begin
      idx_q      <= '0;
      tick_q     <= 1'b0;
      buf_val_q  <= '0;
      buf_dp_q   <= '0;
      buf_en_q   <= '0;
      phase_q    <= BLANK;
      anodes_q   <= '1;
      segments_q <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      tick_q <= bus.scan_tick;
      if (edge_c) begin
        idx_q    <= idx_nxt_c;
        phase_q  <= BLANK;
        anodes_q <= '1;
        // Frame latched only at the wrap so a frame never mixes two values
        if (idx_nxt_c == '0) begin
          buf_val_q <= bus.value;
          buf_dp_q  <= bus.dp_mask;
          buf_en_q  <= bus.digit_en & ~lz_mask_c;
        end
      end else if (phase_q == BLANK) begin
        phase_q    <= DRIVE;
        anodes_q   <= buf_en_q[idx_q] ? ~(N_DIGITS'(1) << idx_q) : '1;
        segments_q <= seg_c;
        dp_q       <= ~buf_dp_q[idx_q];
      end
    end
  end

  assign bus.anodes   = anodes_q;
  assign bus.segments = segments_q;
  assign bus.dp       = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: reference model plus directed literals.
module tb_seg7_scan_driver;
  localparam int unsigned N  = 8;
  localparam int          NI = 8;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk_in;
  logic resetf;
  int   errors;
  int   checks;

  seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

  seg7_scan_driver #(.N_DIGITS(N)) dut (
    .clk_in (clk_in),
    .resetf (resetf),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] lz_blank(input logic [31:0] v);
    logic [7:0] m;
    bit         stop;
    m    = 8'h00;
    stop = 1'b0;
    if (LZ) begin
      for (int k = 7; k >= 1; k--) begin
        if (!stop && v[4*k +: 4] == 4'h0) m[k] = 1'b1;
        else stop = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [7:0] an_of(input int k);
    return ~(8'h01 << k);
  endfunction

  // Reference model: digit position counts edges, frame captured when position returns to 0
  int         m_pos;
  logic       m_prev;
  logic [31:0] m_val;
  logic [7:0] m_dp, m_en, exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk_in or negedge resetf) begin
    if (!resetf) begin
      m_pos   <= 0;
      m_prev  <= 1'b0;
      m_val   <= '0;
      m_dp    <= '0;
      m_en    <= '0;
      exp_an  <= 8'hFF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
    end else begin
      m_prev <= bus.scan_tick;
      if (bus.scan_tick && !m_prev) begin
        m_pos  <= (m_pos + 1) % NI;
        exp_an <= 8'hFF;
        if ((m_pos + 1) % NI == 0) begin
          m_val <= bus.value;
          m_dp  <= bus.dp_mask;
          m_en  <= bus.digit_en & ~lz_blank(bus.value);
        end
      end else begin
        exp_an  <= m_en[m_pos] ? an_of(m_pos) : 8'hFF;
        exp_seg <= SEG[4'((m_val >> (4 * m_pos)) & 32'hF)];
        exp_dp  <= ~m_dp[m_pos];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle, comparing DUT against the model on the falling edge
  task automatic step();
    @(negedge clk_in);
    chk("model_anodes", 32'(bus.anodes), 32'(exp_an));
    chk("model_segments", 32'(bus.segments), 32'(exp_seg));
    chk("model_dp", 32'(bus.dp), 32'(exp_dp));
  endtask

  // One divider period with literal checks on the blank slot and the driven digit
  task automatic edge_chk(input string nm, input int k, input bit lit,
                          input logic [6:0] sg, input bit d);
    bus.scan_tick = 1'b1;
    step();
    chk({nm, "_blank"}, 32'(bus.anodes), 32'hFF);
    bus.scan_tick = 1'b0;
    step();
    chk({nm, "_anodes"}, 32'(bus.anodes), 32'(lit ? an_of(k) : 8'hFF));
    chk({nm, "_seg"}, 32'(bus.segments), 32'(sg));
    chk({nm, "_dp"}, 32'(bus.dp), 32'(d));
    step();
    step();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    resetf        = 1'b0;
    bus.scan_tick = 1'b0;
    bus.value     = 32'h76543210;
    bus.dp_mask   = 8'h00;
    bus.digit_en  = 8'hFF;

    // Reset held while the strobe toggles
    repeat (3) begin
      bus.scan_tick = 1'b1; step();
      bus.scan_tick = 1'b0; step();
    end
    chk("rst_anodes", 32'(bus.anodes), 32'hFF);
    chk("rst_seg", 32'(bus.segments), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);

    resetf = 1'b1;
    step(); step();
    chk("dark_anodes", 32'(bus.anodes), 32'hFF);

    // Basic scan: first pass uses empty buffers, then frame latches at wrap
    for (int k = 1; k < 8; k++) edge_chk("pre", k, 1'b0, 7'h40, 1'b1);
    edge_chk("scan", 0, 1'b1, 7'h40, 1'b1);
    for (int k = 1; k < 8; k++) edge_chk("scan", k, 1'b1, SEG[k], 1'b1);
    edge_chk("wrap", 0, 1'b1, 7'h40, 1'b1);

    // Frame atomicity
    for (int k = 1; k < 4; k++) edge_chk("atom_old", k, 1'b1, SEG[k], 1'b1);
    bus.value = 32'hFFFFFFFF;
    for (int k = 4; k < 8; k++) edge_chk("atom_old", k, 1'b1, SEG[k], 1'b1);
    edge_chk("atom_new", 0, 1'b1, 7'h0E, 1'b1);
    edge_chk("atom_new", 1, 1'b1, 7'h0E, 1'b1);

    // Enable and decimal point
    bus.value    = 32'h76543210;
    bus.digit_en = 8'h0F;
    bus.dp_mask  = 8'h01;
    for (int k = 2; k < 8; k++) edge_chk("en_old", k, 1'b1, 7'h0E, 1'b1);
    edge_chk("en_dp0", 0, 1'b1, 7'h40, 1'b0);
    for (int k = 1; k < 4; k++) edge_chk("en_lit", k, 1'b1, SEG[k], 1'b1);
    for (int k = 4; k < 8; k++) edge_chk("en_dark", k, 1'b0, SEG[k], 1'b1);

    // Strobe stuck high holds the current digit
    bus.scan_tick = 1'b1;
    step();
    chk("held_blank", 32'(bus.anodes), 32'hFF);
    repeat (1000) step();
    chk("held_anodes", 32'(bus.anodes), 32'hFE);
    chk("held_seg", 32'(bus.segments), 32'h40);
    chk("held_dp", 32'(bus.dp), 32'h0);

    // Asynchronous reset mid-drive, away from any clock edge
    #3 resetf = 1'b0;
    #1;
    chk("arst_anodes", 32'(bus.anodes), 32'hFF);
    chk("arst_seg", 32'(bus.segments), 32'h7F);
    chk("arst_dp", 32'(bus.dp), 32'h1);
    bus.scan_tick = 1'b0;
    step(); step();

    // Leading-zero behaviour
    bus.value    = 32'h00000420;
    bus.digit_en = 8'hFF;
    bus.dp_mask  = 8'h00;
    resetf       = 1'b1;
    step();
    for (int k = 1; k < 8; k++) edge_chk("lz_pre", k, 1'b0, 7'h40, 1'b1);
    edge_chk("lz420_d0", 0, 1'b1, 7'h40, 1'b1);
    edge_chk("lz420_d1", 1, 1'b1, 7'h24, 1'b1);
    edge_chk("lz420_d2", 2, 1'b1, 7'h19, 1'b1);
    for (int k = 3; k < 8; k++) edge_chk("lz420_hi", k, !LZ, 7'h40, 1'b1);
    bus.value = 32'h00000000;
    edge_chk("lz0_d0", 0, 1'b1, 7'h40, 1'b1);
    for (int k = 1; k < 8; k++) edge_chk("lz0_hi", k, !LZ, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
